// File: rtl/main_fsm_pkg.sv
// Shared encodings for the RV32I multicycle control sequencer: immediate
// formats, opcodes, state numbering and datapath mux/ALU select codes.
package main_fsm_pkg;

   // Immediate-extender format selects
   localparam logic [2:0] IS_I = 3'd0;
   localparam logic [2:0] IS_S = 3'd1;
   localparam logic [2:0] IS_B = 3'd2;
   localparam logic [2:0] IS_U = 3'd3;
   localparam logic [2:0] IS_J = 3'd4;

   // RV32I base opcodes handled by the sequencer
   localparam logic [6:0] OP_LOAD   = 7'b0000011;
   localparam logic [6:0] OP_STORE  = 7'b0100011;
   localparam logic [6:0] OP_R      = 7'b0110011;
   localparam logic [6:0] OP_IMM    = 7'b0010011;
   localparam logic [6:0] OP_BRANCH = 7'b1100011;
   localparam logic [6:0] OP_JAL    = 7'b1101111;
   localparam logic [6:0] OP_JALR   = 7'b1100111;
   localparam logic [6:0] OP_LUI    = 7'b0110111;
   localparam logic [6:0] OP_AUIPC  = 7'b0010111;

   // Branch flavours that are implemented; others trap
   localparam logic [2:0] F3_BEQ = 3'b000;
   localparam logic [2:0] F3_BNE = 3'b001;

   // ALU operation select
   localparam logic [1:0] ALUOP_ADD   = 2'b00;
   localparam logic [1:0] ALUOP_SUB   = 2'b01;
   localparam logic [1:0] ALUOP_FUNCT = 2'b10;

   // ALU operand A select
   localparam logic [1:0] SRCA_PC    = 2'b00;
   localparam logic [1:0] SRCA_OLDPC = 2'b01;
   localparam logic [1:0] SRCA_RS1   = 2'b10;
   localparam logic [1:0] SRCA_ZERO  = 2'b11;

   // ALU operand B select
   localparam logic [1:0] SRCB_RS2  = 2'b00;
   localparam logic [1:0] SRCB_IMM  = 2'b01;
   localparam logic [1:0] SRCB_FOUR = 2'b10;

   // Register-file write-back source select
   localparam logic [1:0] RES_ALUOUT = 2'b00;
   localparam logic [1:0] RES_RDATA  = 2'b01;
   localparam logic [1:0] RES_ALU    = 2'b10;

   // Sequencer states; numbering is visible on the debug port
   typedef enum logic [3:0] {
      ST_FETCH    = 4'd0,
      ST_DECODE   = 4'd1,
      ST_MEMADR   = 4'd2,
      ST_MEMREAD  = 4'd3,
      ST_MEMWB    = 4'd4,
      ST_MEMWRITE = 4'd5,
      ST_EXECR    = 4'd6,
      ST_EXECI    = 4'd7,
      ST_ALUWB    = 4'd8,
      ST_BRANCH   = 4'd9,
      ST_JAL      = 4'd10,
      ST_JALR     = 4'd11,
      ST_LUI      = 4'd12,
      ST_AUIPC    = 4'd13,
      ST_TRAP     = 4'd14,
      ST_JALRWB   = 4'd15
   } state_t;

endpackage

// File: rtl/main_fsm_ctrl_opdec.sv
// Opcode decoder: immediate format, the state to leave DECODE for, and a
// store flag that splits the shared memory-address state into read/write.
module ctrl_opdec
   import main_fsm_pkg::*;
(
   input  logic [6:0] op_i,
   output logic [2:0] imm_src_o,
   output logic [3:0] dec_next_o,
   output logic       is_store_o
);

   // Table lookup on opcode; unknown opcodes use the I format and trap
   always_comb begin
      imm_src_o  = IS_I;
      dec_next_o = ST_TRAP;
      is_store_o = op_i[5];
      case (op_i)
         OP_LOAD:   begin imm_src_o = IS_I; dec_next_o = ST_MEMADR; end
         OP_STORE:  begin imm_src_o = IS_S; dec_next_o = ST_MEMADR; end
         OP_R:      begin imm_src_o = IS_I; dec_next_o = ST_EXECR;  end
         OP_IMM:    begin imm_src_o = IS_I; dec_next_o = ST_EXECI;  end
         OP_BRANCH: begin imm_src_o = IS_B; dec_next_o = ST_BRANCH; end
         OP_JAL:    begin imm_src_o = IS_J; dec_next_o = ST_JAL;    end
         OP_JALR:   begin imm_src_o = IS_I; dec_next_o = ST_JALR;   end
         OP_LUI:    begin imm_src_o = IS_U; dec_next_o = ST_LUI;    end
         OP_AUIPC:  begin imm_src_o = IS_U; dec_next_o = ST_AUIPC;  end
         default:   begin imm_src_o = IS_I; dec_next_o = ST_TRAP;   end
      endcase
   end

endmodule

// File: rtl/main_fsm.sv
// Multicycle control sequencer for the RV32I core. Steps each instruction
// through fetch/decode/execute/memory/writeback and drives datapath enables
// and selects. Memory requests hold until mem_ready_i; bad opcodes trap.
module main_fsm
   import main_fsm_pkg::*;
(
   input  logic       clk,
   input  logic       rst,
   input  logic [6:0] op_i,
   input  logic [2:0] funct3_i,
   input  logic       zero_i,
   input  logic       mem_ready_i,
   output logic       mem_req_o,
   output logic       mem_we_o,
   output logic       adr_src_o,
   output logic       ir_write_o,
   output logic       pc_write_o,
   output logic [2:0] imm_src_o,
   output logic [1:0] alu_src_a_o,
   output logic [1:0] alu_src_b_o,
   output logic [1:0] alu_op_o,
   output logic [1:0] result_src_o,
   output logic       reg_write_o,
   output logic       illegal_o,
   output logic [3:0] state_o
);

   state_t     state;
   state_t     next_state;
   logic       illegal_q;
   logic [2:0] dec_imm_src;
   logic [3:0] dec_next;
   logic       dec_is_store;

   ctrl_opdec u_opdec (
      .op_i       (op_i),
      .imm_src_o  (dec_imm_src),
      .dec_next_o (dec_next),
      .is_store_o (dec_is_store)
   );

   // State register and sticky trap flag; reset abandons any access in flight
   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= ST_FETCH;
         illegal_q <= 1'b0;
      end else begin
         state <= next_state;
         if (next_state == ST_TRAP) begin
            illegal_q <= 1'b1;
         end
      end
   end

   // Next-state and per-state output decode; everything idles at 0 by default
   always_comb begin
      next_state   = state;
      mem_req_o    = 1'b0;
      mem_we_o     = 1'b0;
      adr_src_o    = 1'b0;
      ir_write_o   = 1'b0;
      pc_write_o   = 1'b0;
      imm_src_o    = dec_imm_src;
      alu_src_a_o  = SRCA_PC;
      alu_src_b_o  = SRCB_RS2;
      alu_op_o     = ALUOP_ADD;
      result_src_o = RES_ALUOUT;
      reg_write_o  = 1'b0;
      case (state)
         ST_FETCH: begin
            mem_req_o = 1'b1;
            if (mem_ready_i) begin
               ir_write_o   = 1'b1;
               pc_write_o   = 1'b1;
               alu_src_a_o  = SRCA_PC;
               alu_src_b_o  = SRCB_FOUR;
               alu_op_o     = ALUOP_ADD;
               result_src_o = RES_ALU;
               next_state   = ST_DECODE;
            end
         end
         ST_DECODE: begin
            alu_src_a_o = SRCA_OLDPC;
            alu_src_b_o = SRCB_IMM;
            alu_op_o    = ALUOP_ADD;
            next_state  = state_t'(dec_next);
         end
         ST_MEMADR: begin
            alu_src_a_o = SRCA_RS1;
            alu_src_b_o = SRCB_IMM;
            alu_op_o    = ALUOP_ADD;
            next_state  = dec_is_store ? ST_MEMWRITE : ST_MEMREAD;
         end
         ST_MEMREAD: begin
            mem_req_o = 1'b1;
            adr_src_o = 1'b1;
            if (mem_ready_i) begin
               next_state = ST_MEMWB;
            end
         end
         ST_MEMWB: begin
            result_src_o = RES_RDATA;
            reg_write_o  = 1'b1;
            next_state   = ST_FETCH;
         end
         ST_MEMWRITE: begin
            mem_req_o = 1'b1;
            mem_we_o  = 1'b1;
            adr_src_o = 1'b1;
            if (mem_ready_i) begin
               next_state = ST_FETCH;
            end
         end
         ST_EXECR: begin
            alu_src_a_o = SRCA_RS1;
            alu_src_b_o = SRCB_RS2;
            alu_op_o    = ALUOP_FUNCT;
            next_state  = ST_ALUWB;
         end
         ST_EXECI: begin
            alu_src_a_o = SRCA_RS1;
            alu_src_b_o = SRCB_IMM;
            alu_op_o    = ALUOP_FUNCT;
            next_state  = ST_ALUWB;
         end
         ST_ALUWB: begin
            result_src_o = RES_ALUOUT;
            reg_write_o  = 1'b1;
            next_state   = ST_FETCH;
         end
         ST_BRANCH: begin
            alu_src_a_o  = SRCA_RS1;
            alu_src_b_o  = SRCB_RS2;
            alu_op_o     = ALUOP_SUB;
            result_src_o = RES_ALUOUT;
            next_state   = ST_FETCH;
            if (funct3_i == F3_BEQ) begin
               pc_write_o = zero_i;
            end else if (funct3_i == F3_BNE) begin
               pc_write_o = ~zero_i;
            end else begin
               next_state = ST_TRAP;
            end
         end
         ST_JAL: begin
            alu_src_a_o  = SRCA_OLDPC;
            alu_src_b_o  = SRCB_FOUR;
            alu_op_o     = ALUOP_ADD;
            result_src_o = RES_ALUOUT;
            pc_write_o   = 1'b1;
            next_state   = ST_ALUWB;
         end
         ST_JALR: begin
            alu_src_a_o  = SRCA_RS1;
            alu_src_b_o  = SRCB_IMM;
            alu_op_o     = ALUOP_ADD;
            result_src_o = RES_ALU;
            pc_write_o   = 1'b1;
            next_state   = ST_JALRWB;
         end
         ST_JALRWB: begin
            alu_src_a_o  = SRCA_OLDPC;
            alu_src_b_o  = SRCB_FOUR;
            alu_op_o     = ALUOP_ADD;
            result_src_o = RES_ALU;
            reg_write_o  = 1'b1;
            next_state   = ST_FETCH;
         end
         ST_LUI: begin
            alu_src_a_o = SRCA_ZERO;
            alu_src_b_o = SRCB_IMM;
            next_state  = ST_ALUWB;
         end
         ST_AUIPC: begin
            alu_src_a_o = SRCA_OLDPC;
            alu_src_b_o = SRCB_IMM;
            next_state  = ST_ALUWB;
         end
         ST_TRAP: begin
            next_state = ST_TRAP;
         end
         default: begin
            next_state = ST_TRAP;
         end
      endcase
   end

   assign illegal_o = illegal_q;
   assign state_o   = state;

endmodule

// File: tb/tb_main_fsm.sv
// Scoreboard bench for main_fsm: the stimulus process drives one cycle at a
// time and queues the hand-written expected outputs for that cycle; a
// negedge monitor pops and compares them against the DUT.
module tb_main_fsm;

   logic       clk = 1'b0;
   logic       rst;
   logic [6:0] op_i;
   logic [2:0] funct3_i;
   logic       zero_i;
   logic       mem_ready_i;
   logic       mem_req_o;
   logic       mem_we_o;
   logic       adr_src_o;
   logic       ir_write_o;
   logic       pc_write_o;
   logic [2:0] imm_src_o;
   logic [1:0] alu_src_a_o;
   logic [1:0] alu_src_b_o;
   logic [1:0] alu_op_o;
   logic [1:0] result_src_o;
   logic       reg_write_o;
   logic       illegal_o;
   logic [3:0] state_o;

   typedef struct {
      logic [21:0] v;
      string       nm;
   } exp_t;

   exp_t sbq[$];
   int   total = 0;
   int   bad   = 0;

   localparam logic [6:0] R_OP   = 7'b0110011;
   localparam logic [6:0] LW_OP  = 7'b0000011;
   localparam logic [6:0] SW_OP  = 7'b0100011;
   localparam logic [6:0] BR_OP  = 7'b1100011;
   localparam logic [6:0] IMM_OP = 7'b0010011;
   localparam logic [6:0] JAL_OP = 7'b1101111;
   localparam logic [6:0] JR_OP  = 7'b1100111;
   localparam logic [6:0] LUI_OP = 7'b0110111;
   localparam logic [6:0] AUI_OP = 7'b0010111;

   main_fsm dut (
      .clk          (clk),
      .rst          (rst),
      .op_i         (op_i),
      .funct3_i     (funct3_i),
      .zero_i       (zero_i),
      .mem_ready_i  (mem_ready_i),
      .mem_req_o    (mem_req_o),
      .mem_we_o     (mem_we_o),
      .adr_src_o    (adr_src_o),
      .ir_write_o   (ir_write_o),
      .pc_write_o   (pc_write_o),
      .imm_src_o    (imm_src_o),
      .alu_src_a_o  (alu_src_a_o),
      .alu_src_b_o  (alu_src_b_o),
      .alu_op_o     (alu_op_o),
      .result_src_o (result_src_o),
      .reg_write_o  (reg_write_o),
      .illegal_o    (illegal_o),
      .state_o      (state_o)
   );

   // 10 time-unit core clock
   always #5 clk = ~clk;

   logic [21:0] act;
   assign act = {state_o, mem_req_o, mem_we_o, adr_src_o, ir_write_o, pc_write_o,
                 imm_src_o, alu_src_a_o, alu_src_b_o, alu_op_o, result_src_o,
                 reg_write_o, illegal_o};

   // Packs one expected output vector in the same field order as act
   function automatic logic [21:0] e(input int st, input int m, input int w, input int a,
                                     input int ir, input int pc, input int imm, input int sa,
                                     input int sb, input int ao, input int rs, input int rw,
                                     input int il);
      return {4'(st), 1'(m), 1'(w), 1'(a), 1'(ir), 1'(pc), 3'(imm), 2'(sa), 2'(sb),
              2'(ao), 2'(rs), 1'(rw), 1'(il)};
   endfunction

   function automatic logic [21:0] fetchWait(input int imm);
      return e(0, 1, 0, 0, 0, 0, imm, 0, 0, 0, 0, 0, 0);
   endfunction

   function automatic logic [21:0] fetchDone(input int imm);
      return e(0, 1, 0, 0, 1, 1, imm, 0, 2, 0, 2, 0, 0);
   endfunction

   function automatic logic [21:0] decodeExp(input int imm);
      return e(1, 0, 0, 0, 0, 0, imm, 1, 1, 0, 0, 0, 0);
   endfunction

   function automatic logic [21:0] aluWb(input int imm);
      return e(8, 0, 0, 0, 0, 0, imm, 0, 0, 0, 0, 1, 0);
   endfunction

   // Drives one cycle of inputs and queues what the outputs must be in it
   task automatic applyStimulus(input logic r, input logic [6:0] op, input logic [2:0] f3,
                                input logic z, input logic rdy, input logic [21:0] ex,
                                input string nm);
      exp_t it;
      rst         = r;
      op_i        = op;
      funct3_i    = f3;
      zero_i      = z;
      mem_ready_i = rdy;
      it.v  = ex;
      it.nm = nm;
      sbq.push_back(it);
      @(posedge clk);
      #1;
   endtask

   task automatic checkOutput(input exp_t it);
      total++;
      if (act !== it.v) begin
         bad++;
         $display("[TB] FAIL %s: got %h (state %0d) want %h (state %0d)",
                  it.nm, act, act[21:18], it.v, it.v[21:18]);
      end
   endtask

   // Monitor: compare whatever cycle the stimulus has queued an expectation for
   always @(negedge clk) begin
      if (sbq.size() > 0) begin
         checkOutput(sbq.pop_front());
      end
   end

   initial begin
      #200000;
      $display("[TB] FAIL timeout: got no finish want finish");
      $fatal(1, "[TB] timeout");
   end

   initial begin
      rst = 1'b1; op_i = R_OP; funct3_i = 3'b000; zero_i = 1'b0; mem_ready_i = 1'b0;
      @(posedge clk);
      #1;

      // Reset state: FETCH waiting on memory
      applyStimulus(0, R_OP, 3'b000, 0, 0, fetchWait(0), "rst_fetch");

      // R-type add, zero wait states
      applyStimulus(0, R_OP, 3'b000, 0, 1, fetchDone(0), "r_fetch");
      applyStimulus(0, R_OP, 3'b000, 0, 1, decodeExp(0), "r_decode");
      applyStimulus(0, R_OP, 3'b000, 0, 1, e(6, 0, 0, 0, 0, 0, 0, 2, 0, 2, 0, 0, 0), "r_exec");
      applyStimulus(0, R_OP, 3'b000, 0, 1, aluWb(0), "r_wb");

      // lw with two wait states in MEMREAD
      applyStimulus(0, LW_OP, 3'b010, 0, 1, fetchDone(0), "lw_fetch");
      applyStimulus(0, LW_OP, 3'b010, 0, 1, decodeExp(0), "lw_decode");
      applyStimulus(0, LW_OP, 3'b010, 0, 1, e(2, 0, 0, 0, 0, 0, 0, 2, 1, 0, 0, 0, 0), "lw_memadr");
      applyStimulus(0, LW_OP, 3'b010, 0, 0, e(3, 1, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0), "lw_rd_wait1");
      applyStimulus(0, LW_OP, 3'b010, 0, 0, e(3, 1, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0), "lw_rd_wait2");
      applyStimulus(0, LW_OP, 3'b010, 0, 1, e(3, 1, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0), "lw_rd_done");
      applyStimulus(0, LW_OP, 3'b010, 0, 1, e(4, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 0), "lw_memwb");

      // sw, zero wait states
      applyStimulus(0, SW_OP, 3'b010, 0, 1, fetchDone(1), "sw_fetch");
      applyStimulus(0, SW_OP, 3'b010, 0, 1, decodeExp(1), "sw_decode");
      applyStimulus(0, SW_OP, 3'b010, 0, 1, e(2, 0, 0, 0, 0, 0, 1, 2, 1, 0, 0, 0, 0), "sw_memadr");
      applyStimulus(0, SW_OP, 3'b010, 0, 1, e(5, 1, 1, 1, 0, 0, 1, 0, 0, 0, 0, 0, 0), "sw_memwrite");

      // beq / bne taken and not taken
      for (int k = 0; k < 4; k++) begin
         logic [2:0] f3;
         logic       z;
         int         pcw;
         f3  = (k < 2) ? 3'b000 : 3'b001;
         z   = (k == 0 || k == 3) ? 1'b1 : 1'b0;
         pcw = (k == 0 || k == 2) ? 1 : 0;
         applyStimulus(0, BR_OP, f3, z, 1, fetchDone(2), "br_fetch");
         applyStimulus(0, BR_OP, f3, z, 1, decodeExp(2), "br_decode");
         applyStimulus(0, BR_OP, f3, z, 1, e(9, 0, 0, 0, 0, pcw, 2, 2, 0, 1, 0, 0, 0), "br_exec");
      end

      // Unsupported branch funct3 traps without writing the PC
      applyStimulus(0, BR_OP, 3'b100, 1, 1, fetchDone(2), "blt_fetch");
      applyStimulus(0, BR_OP, 3'b100, 1, 1, decodeExp(2), "blt_decode");
      applyStimulus(0, BR_OP, 3'b100, 1, 1, e(9, 0, 0, 0, 0, 0, 2, 2, 0, 1, 0, 0, 0), "blt_branch");
      applyStimulus(0, BR_OP, 3'b100, 1, 1, e(14, 0, 0, 0, 0, 0, 2, 0, 0, 0, 0, 0, 1), "blt_trap");
      applyStimulus(1, BR_OP, 3'b100, 1, 1, e(14, 0, 0, 0, 0, 0, 2, 0, 0, 0, 0, 0, 1), "blt_trap_rst");
      applyStimulus(0, BR_OP, 3'b100, 1, 0, fetchWait(2), "blt_after_rst");

      // Opcode 0 traps and holds until reset
      applyStimulus(0, 7'b0000000, 3'b000, 0, 1, fetchDone(0), "ill_fetch");
      applyStimulus(0, 7'b0000000, 3'b000, 0, 1, decodeExp(0), "ill_decode");
      for (int k = 0; k < 10; k++) begin
         applyStimulus(0, 7'b0000000, 3'b000, 0, 1, e(14, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1), "ill_hold");
      end
      applyStimulus(1, 7'b0000000, 3'b000, 0, 1, e(14, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1), "ill_rst");
      applyStimulus(0, 7'b0000000, 3'b000, 0, 0, fetchWait(0), "ill_after_rst");

      // OP-IMM
      applyStimulus(0, IMM_OP, 3'b000, 0, 1, fetchDone(0), "imm_fetch");
      applyStimulus(0, IMM_OP, 3'b000, 0, 1, decodeExp(0), "imm_decode");
      applyStimulus(0, IMM_OP, 3'b000, 0, 1, e(7, 0, 0, 0, 0, 0, 0, 2, 1, 2, 0, 0, 0), "imm_exec");
      applyStimulus(0, IMM_OP, 3'b000, 0, 1, aluWb(0), "imm_wb");

      // JAL
      applyStimulus(0, JAL_OP, 3'b000, 0, 1, fetchDone(4), "jal_fetch");
      applyStimulus(0, JAL_OP, 3'b000, 0, 1, decodeExp(4), "jal_decode");
      applyStimulus(0, JAL_OP, 3'b000, 0, 1, e(10, 0, 0, 0, 0, 1, 4, 1, 2, 0, 0, 0, 0), "jal_exec");
      applyStimulus(0, JAL_OP, 3'b000, 0, 1, aluWb(4), "jal_wb");

      // JALR
      applyStimulus(0, JR_OP, 3'b000, 0, 1, fetchDone(0), "jalr_fetch");
      applyStimulus(0, JR_OP, 3'b000, 0, 1, decodeExp(0), "jalr_decode");
      applyStimulus(0, JR_OP, 3'b000, 0, 1, e(11, 0, 0, 0, 0, 1, 0, 2, 1, 0, 2, 0, 0), "jalr_exec");
      applyStimulus(0, JR_OP, 3'b000, 0, 1, e(15, 0, 0, 0, 0, 0, 0, 1, 2, 0, 2, 1, 0), "jalr_wb");

      // LUI
      applyStimulus(0, LUI_OP, 3'b000, 0, 1, fetchDone(3), "lui_fetch");
      applyStimulus(0, LUI_OP, 3'b000, 0, 1, decodeExp(3), "lui_decode");
      applyStimulus(0, LUI_OP, 3'b000, 0, 1, e(12, 0, 0, 0, 0, 0, 3, 3, 1, 0, 0, 0, 0), "lui_exec");
      applyStimulus(0, LUI_OP, 3'b000, 0, 1, aluWb(3), "lui_wb");

      // AUIPC
      applyStimulus(0, AUI_OP, 3'b000, 0, 1, fetchDone(3), "auipc_fetch");
      applyStimulus(0, AUI_OP, 3'b000, 0, 1, decodeExp(3), "auipc_decode");
      applyStimulus(0, AUI_OP, 3'b000, 0, 1, e(13, 0, 0, 0, 0, 0, 3, 1, 1, 0, 0, 0, 0), "auipc_exec");
      applyStimulus(0, AUI_OP, 3'b000, 0, 1, aluWb(3), "auipc_wb");

      // Reset while a store is stalled abandons it and restarts with a fetch
      applyStimulus(0, SW_OP, 3'b010, 0, 1, fetchDone(1), "swr_fetch");
      applyStimulus(0, SW_OP, 3'b010, 0, 1, decodeExp(1), "swr_decode");
      applyStimulus(0, SW_OP, 3'b010, 0, 1, e(2, 0, 0, 0, 0, 0, 1, 2, 1, 0, 0, 0, 0), "swr_memadr");
      applyStimulus(1, SW_OP, 3'b010, 0, 0, e(5, 1, 1, 1, 0, 0, 1, 0, 0, 0, 0, 0, 0), "swr_memwrite_rst");
      applyStimulus(0, SW_OP, 3'b010, 0, 0, fetchWait(1), "swr_after_rst");

      // Let the monitor drain anything still queued
      for (int k = 0; k < 4 && sbq.size() > 0; k++) begin
         @(negedge clk);
         #1;
      end
      if (sbq.size() > 0) begin
         $display("[TB] FAIL drain: got %0d pending want 0", sbq.size());
         bad++;
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
